// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Sequences multi-cycle data-memory accesses (request held until ack or
// timeout) and merges the resulting freeze with the load-use stall and the
// ID-stage branch flush into per-stage write enables, PC write, ID/EX bubble
// and IF/ID flush. Also flags memory timeouts (sticky) and counts stalls.
//
// Parameters:
//   TIMEOUT  max BUSY cycles waiting for mem_ack_i before forced release
//   CNT_W    width of BUSY-cycle counter (2**CNT_W > TIMEOUT)
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   MemRead_MEM_i         MEM-stage load
//   MemWrite_MEM_i        MEM-stage store
//   mem_ack_i             data memory completed current request
//   Hazard_Stall_i        load-use stall request
//   Branch_Taken_i        ID-stage branch resolved taken
//   mem_req_o             data-memory request, held until ack/timeout
//   PCWrite_o, IFID_Write_o, IDEX_Write_o, EXMEM_Write_o, MEMWB_Write_o
//                         pipeline register write enables
//   NoOp_o                bubble into ID/EX
//   IFID_Flush_o          squash fetched instruction
//   err_o                 sticky memory-timeout flag
//   stall_total_o         saturating count of frozen/stalled cycles
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_MEM_i,
  input  logic        MemWrite_MEM_i,
  input  logic        mem_ack_i,
  input  logic        Hazard_Stall_i,
  input  logic        Branch_Taken_i,
  output logic        mem_req_o,
  output logic        PCWrite_o,
  output logic        IFID_Write_o,
  output logic        IDEX_Write_o,
  output logic        EXMEM_Write_o,
  output logic        MEMWB_Write_o,
  output logic        NoOp_o,
  output logic        IFID_Flush_o,
  output logic        err_o,
  output logic [31:0] stall_total_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] busy_cnt;
  logic             mem_op;
  logic             mem_freeze;
  logic             hz_stall;
  logic             timeout_hit;

  assign mem_op = MemRead_MEM_i | MemWrite_MEM_i;

  // Ack has priority: a timeout only fires when no ack arrives that cycle.
  assign timeout_hit = (state == BUSY) && !mem_ack_i &&
                       (busy_cnt == CNT_W'(TIMEOUT - 1));

  // Reset gating keeps the enables open while rst_i is held, even if a
  // memory op or stall request is presented during reset.
  assign mem_freeze = !rst_i && (((state == IDLE) && mem_op) || (state == BUSY));
  assign hz_stall   = !rst_i && !mem_freeze && Hazard_Stall_i;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mem_op) state_nxt = BUSY;
      BUSY:    if (mem_ack_i || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o     = !rst_i && (state == BUSY);
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IDEX_Write_o  = 1'b1;
    EXMEM_Write_o = 1'b1;
    MEMWB_Write_o = 1'b1;
    NoOp_o        = 1'b0;
    IFID_Flush_o  = 1'b0;
    if (mem_freeze) begin
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Write_o  = 1'b0;
      EXMEM_Write_o = 1'b0;
      MEMWB_Write_o = 1'b0;
    end else if (hz_stall) begin
      // Stall wins over flush: the branch sitting in ID is not yet resolved.
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      NoOp_o       = 1'b1;
    end else if (!rst_i && Branch_Taken_i) begin
      IFID_Flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      busy_cnt      <= '0;
      err_o         <= 1'b0;
      stall_total_o <= '0;
    end else begin
      state <= state_nxt;
      if ((state == BUSY) && !mem_ack_i && !timeout_hit)
        busy_cnt <= busy_cnt + 1'b1;
      else
        busy_cnt <= '0;
      if (timeout_hit)
        err_o <= 1'b1;
      if ((mem_freeze || hz_stall) && (stall_total_o != '1))
        stall_total_o <= stall_total_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr, mw, ack, hz, br;
  logic        mem_req, pcw, ifw, idw, exw, mww, noop, flush, err;
  logic [31:0] stall_total;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one access "in flight" with a count of waited cycles,
  // plus a one-cycle release slot after each access completes.
  bit          in_flight;
  bit          releasing;
  int          waited;
  bit          m_err;
  logic [31:0] m_stall;

  pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .MemRead_MEM_i(mr), .MemWrite_MEM_i(mw), .mem_ack_i(ack),
    .Hazard_Stall_i(hz), .Branch_Taken_i(br),
    .mem_req_o(mem_req), .PCWrite_o(pcw), .IFID_Write_o(ifw),
    .IDEX_Write_o(idw), .EXMEM_Write_o(exw), .MEMWB_Write_o(mww),
    .NoOp_o(noop), .IFID_Flush_o(flush), .err_o(err),
    .stall_total_o(stall_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit m_freeze();
    return !releasing && (in_flight || mr || mw);
  endfunction

  // {req, pc, ifid, idex, exmem, memwb, noop, flush}
  function automatic logic [7:0] m_outs();
    if (m_freeze())  return {in_flight, 5'b00000, 2'b00};
    else if (hz)     return {1'b0, 5'b00111, 2'b10};
    else if (br)     return {1'b0, 5'b11111, 2'b01};
    else             return {1'b0, 5'b11111, 2'b00};
  endfunction

  task automatic model_reset();
    in_flight = 0; releasing = 0; waited = 0; m_err = 0; m_stall = '0;
  endtask

  task automatic model_step();
    if ((m_freeze() || hz) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (releasing) begin
      releasing = 0;
    end else if (in_flight) begin
      waited++;
      if (ack) begin
        in_flight = 0; releasing = 1;
      end else if (waited == TO) begin
        m_err = 1; in_flight = 0; releasing = 1;
      end
    end else if (mr || mw) begin
      in_flight = 1; waited = 0;
    end
  endtask

  // Called at a negedge: drive inputs, check, advance one clock.
  task automatic step(input bit i_mr, i_mw, i_ack, i_hz, i_br);
    mr = i_mr; mw = i_mw; ack = i_ack; hz = i_hz; br = i_br;
    #1;
    check("outs", {mem_req, pcw, ifw, idw, exw, mww, noop, flush}, m_outs());
    check("err", err, m_err);
    check("stall_total", stall_total, m_stall);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mr = 1; mw = 1; ack = 0; hz = 1; br = 1;
    model_reset();
    #3;
    check("rst_forced_outs", {mem_req, pcw, ifw, idw, exw, mww, noop, flush}, 8'b0_11111_00);
    check("rst_err", err, 1'b0);
    check("rst_stall", stall_total, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load, ack on the 3rd BUSY cycle: 4 frozen cycles then DONE.
    step(1,0,0,0,0);
    step(1,0,0,0,0);
    step(1,0,0,0,0);
    step(1,0,1,0,0);
    step(1,0,0,0,0);
    check("load_stall_total", stall_total, 32'd4);

    // Single load-use stall, branch alone, branch with stall.
    step(0,0,0,1,0);
    check("hz_stall_total", stall_total, 32'd5);
    step(0,0,0,0,1);
    step(0,0,0,1,1);

    // Store with stall and branch held; stall outputs appear in DONE.
    step(0,1,1,1,1);
    step(0,1,0,1,1);
    step(0,1,1,1,1);
    step(0,1,0,1,1);

    // Zero-latency memory, then back-to-back access right after DONE.
    step(1,0,0,0,0);
    step(1,0,1,0,0);
    step(0,1,0,0,0);
    step(0,1,0,0,0);
    step(0,1,1,0,0);
    step(0,0,0,0,0);

    // Timeout: never ack.
    step(1,0,0,0,0);
    for (int i = 0; i < TO; i++) step(1,0,0,0,0);
    step(1,0,0,0,0);
    check("timeout_err", err, 1'b1);
    step(0,0,0,0,0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(9) < 3,
           $urandom_range(9) < 3, $urandom_range(9) < 3);
    check("err_sticky_after_random", err, m_err);

    // Async reset mid-BUSY.
    step(1,0,0,0,0);
    step(1,0,0,0,0);
    check("busy_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", mem_req, 1'b0);
    check("async_rst_err", err, 1'b0);
    check("async_rst_stall", stall_total, 32'd0);
    check("async_rst_outs", {pcw, ifw, idw, exw, mww, noop, flush}, 7'b11111_00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1,0,0,0,0);
    step(1,0,0,0,0);
    step(1,0,1,0,0);
    step(0,0,0,0,0);
    check("post_rst_stall", stall_total, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
